// File: rtl/branch_seq.sv
// branch_seq: sequences the ID-stage branch comparator.
// It accepts a branch from decode and stalls IF/ID until the branch's operands are ready.
// It drives the comparator from registered operands and samples its result.
// A taken result produces a one-cycle PC redirect pulse.
// A branch that arrives in the delay slot is reported on err and is not accepted.
// The optional statistics counters are enabled by defining BRANCH_SEQ_STATS_EN.
module branch_seq #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    input  logic [2:0]  br_op,
    input  logic [31:0] br_pc,
    input  logic [15:0] br_off,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rs_rdy,
    input  logic        rt_rdy,
    output logic [31:0] cmp_a,
    output logic [31:0] cmp_b,
    output logic [2:0]  cmp_op,
    input  logic        cmp_br,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        err,
    output logic [31:0] taken_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_OPS,
        S_EVAL,
        S_SLOT
    } state_t;

    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cmp_a;
    logic [31:0] r_cmp_b;
    logic [2:0]  r_cmp_op;
    logic [31:0] r_pc;
    logic [15:0] r_off;
    logic [3:0]  r_wait_cnt;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_err;

    logic        w_idle_rdy;
    logic        w_wait_rdy;
    logic        w_accept;
    logic        w_start_wait;
    logic        w_load_ops;
    logic        w_inc_wait;
    logic        w_take;
    logic        w_err_nxt;
    logic        w_stall;
    logic [31:0] w_target;

    // Ops 0,1 compare rs with rt, ops 2-5 test rs only, and op 6 needs no operand.
    function automatic logic f_ops_rdy(input logic [2:0] op, input logic rs, input logic rt);
        logic rdy;
        case (op)
            3'd0, 3'd1:                     rdy = rs & rt;
            3'd2, 3'd3, 3'd4, 3'd5:         rdy = rs;
            default:                        rdy = 1'b1;
        endcase
        return rdy;
    endfunction

    assign w_idle_rdy = f_ops_rdy(br_op, rs_rdy, rt_rdy);
    assign w_wait_rdy = f_ops_rdy(r_cmp_op, rs_rdy, rt_rdy);
    assign w_target   = r_pc + 32'd4 + {{14{r_off[15]}}, r_off, 2'b00};

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_start_wait = 1'b0;
        w_load_ops   = 1'b0;
        w_inc_wait   = 1'b0;
        w_take       = 1'b0;
        w_err_nxt    = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (br_valid) begin
                    if (br_op == OP_ILLEGAL) begin
                        w_err_nxt = 1'b1;
                    end else if (w_idle_rdy) begin
                        w_accept    = 1'b1;
                        w_load_ops  = 1'b1;
                        w_state_nxt = S_EVAL;
                    end else begin
                        w_accept     = 1'b1;
                        w_start_wait = 1'b1;
                        w_stall      = 1'b1;
                        w_state_nxt  = S_WAIT_OPS;
                    end
                end
            end
            S_WAIT_OPS: begin
                w_stall = 1'b1;
                if (w_wait_rdy) begin
                    w_load_ops  = 1'b1;
                    w_state_nxt = S_EVAL;
                end else if (r_wait_cnt == 4'(MAX_WAIT)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_inc_wait = 1'b1;
                end
            end
            S_EVAL: begin
                w_take      = cmp_br;
                w_state_nxt = S_SLOT;
            end
            S_SLOT: begin
                w_err_nxt   = br_valid;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Latched branch fields, comparator operands, watchdog and output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_a       <= '0;
            r_cmp_b       <= '0;
            r_cmp_op      <= '0;
            r_pc          <= '0;
            r_off         <= '0;
            r_wait_cnt    <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmp_op <= br_op;
                r_pc     <= br_pc;
                r_off    <= br_off;
            end
            if (w_load_ops) begin
                r_cmp_a <= rs_val;
                r_cmp_b <= rt_val;
            end
            if (w_start_wait)    r_wait_cnt <= 4'd1;
            else if (w_inc_wait) r_wait_cnt <= r_wait_cnt + 4'd1;
            r_redirect <= w_take;
            if (w_take) r_redirect_pc <= w_target;
            r_err <= w_err_nxt;
        end
    end

`ifdef BRANCH_SEQ_STATS_EN
    logic [31:0] r_taken_cnt;
    logic [31:0] r_stall_cnt;

    // Statistics counters: taken branches and stalled cycles; both wrap at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_take)  r_taken_cnt <= r_taken_cnt + 32'd1;
            if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign taken_cnt = r_taken_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign taken_cnt = '0;
    assign stall_cnt = '0;
`endif

    assign cmp_a       = r_cmp_a;
    assign cmp_b       = r_cmp_b;
    assign cmp_op      = r_cmp_op;
    assign stall       = w_stall;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign busy        = (r_state != S_IDLE);
    assign err         = r_err;

endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: this bench drives complete branch transactions into branch_seq.
// It predicts every output per cycle from the transaction's parameters: op, operands, and operand-ready delays.
// It also acts as the external comparator.
module tb_branch_seq;

    localparam int unsigned MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic [2:0]  br_op;
    logic [31:0] br_pc;
    logic [15:0] br_off;
    logic [31:0] rs_val, rt_val;
    logic        rs_rdy, rt_rdy;
    logic [31:0] cmp_a, cmp_b;
    logic [2:0]  cmp_op;
    logic        cmp_br;
    logic        stall, redirect, busy, err;
    logic [31:0] redirect_pc, taken_cnt, stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_target = '0;
    logic [31:0] m_taken  = '0;
    logic [31:0] m_stall  = '0;

    always #5 clk = ~clk;

    branch_seq #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_op(br_op), .br_pc(br_pc),
        .br_off(br_off), .rs_val(rs_val), .rt_val(rt_val), .rs_rdy(rs_rdy), .rt_rdy(rt_rdy),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_op(cmp_op), .cmp_br(cmp_br), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy), .err(err),
        .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    // Branch condition: beq, bne, bltz, blez, bgtz, bgez, always.
    function automatic logic f_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) < 0;
            3'd3:    return $signed(a) <= 0;
            3'd4:    return $signed(a) > 0;
            3'd5:    return $signed(a) >= 0;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // External comparator.
    always_comb cmp_br = f_taken(cmp_op, cmp_a, cmp_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef BRANCH_SEQ_STATS_EN
        check("taken_cnt", taken_cnt, m_taken);
        check("stall_cnt", stall_cnt, m_stall);
`else
        check("taken_cnt", taken_cnt, 32'd0);
        check("stall_cnt", stall_cnt, 32'd0);
`endif
    endtask

    // One branch transaction.
    // Cycle 0 presents the branch, and rs/rt become ready at cycles rs_d/rt_d.
    // When slot=1, a second branch is placed in the delay slot.
    task automatic run_br(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] off,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input int rs_d, input int rt_d, input bit slot);
        bit legal, timeout, tk;
        int k, last;
        logic e_stall, e_busy, e_redir, e_err;
        legal = (op != 3'd7);
        if (op <= 3'd1)      k = (rs_d > rt_d) ? rs_d : rt_d;
        else if (op <= 3'd5) k = rs_d;
        else                 k = 0;
        timeout = legal && (k > int'(MAXW));
        tk      = f_taken(op, rs, rt);
        last    = !legal ? 1 : (timeout ? int'(MAXW) + 1 : k + 3);
        for (int j = 0; j <= last; j++) begin
            if (!legal)       br_valid = (j == 0);
            else if (timeout) br_valid = (j <= int'(MAXW));
            else              br_valid = (j <= k) || (slot && j == k + 2);
            br_op  = op;
            br_pc  = pc;
            br_off = off;
            rs_val = rs;
            rt_val = rt;
            rs_rdy = (j >= rs_d);
            rt_rdy = (j >= rt_d);
            #3;
            if (!legal) begin
                e_stall = 1'b0; e_busy = 1'b0; e_redir = 1'b0; e_err = (j == 1);
            end else if (timeout) begin
                e_stall = (j <= int'(MAXW));
                e_busy  = (j >= 1) && (j <= int'(MAXW));
                e_redir = 1'b0;
                e_err   = (j == int'(MAXW) + 1);
            end else begin
                e_stall = (k > 0) && (j <= k);
                e_busy  = (j >= 1) && (j <= k + 2);
                e_redir = tk && (j == k + 2);
                e_err   = slot && (j == k + 3);
            end
            if (e_redir) begin
                m_target = pc + 32'd4 + 32'($signed(off) * 4);
                m_taken  = m_taken + 32'd1;
            end
            check("stall", {31'd0, stall}, {31'd0, e_stall});
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("redirect", {31'd0, redirect}, {31'd0, e_redir});
            check("err", {31'd0, err}, {31'd0, e_err});
            check("redirect_pc", redirect_pc, m_target);
            check_stats();
            if (legal && !timeout && j == k + 1) begin
                check("cmp_a", cmp_a, rs);
                check("cmp_b", cmp_b, rt);
                check("cmp_op", {29'd0, cmp_op}, {29'd0, op});
            end
            if (e_stall) m_stall = m_stall + 32'd1;
            @(posedge clk);
            #1;
        end
        br_valid = 1'b0;
        rs_rdy   = 1'b0;
        rt_rdy   = 1'b0;
    endtask

    initial begin
        logic [31:0] vals [8];
        logic [31:0] a, b;
        logic [2:0]  op;
        vals = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h5, 32'h7, 32'h12345678};

        rst_n = 1'b0; br_valid = 1'b0; br_op = '0; br_pc = '0; br_off = '0;
        rs_val = '0; rt_val = '0; rs_rdy = 1'b0; rt_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_cmp_a", cmp_a, 32'd0);
        check("rst_cmp_b", cmp_b, 32'd0);
        check("rst_cmp_op", {29'd0, cmp_op}, 32'd0);
        check_stats();
        rst_n = 1'b1;

        // Directed scenarios
        run_br(3'd0, 32'h100, 16'h0003, 32'd5, 32'd5, 0, 0, 0);
        check("beq_target", redirect_pc, 32'h110);
        run_br(3'd1, 32'h140, 16'h0020, 32'd7, 32'd7, 0, 0, 0);
        run_br(3'd2, 32'h200, 16'hFFFF, 32'hFFFFFFFF, 32'd0, 2, 0, 0);
        check("bltz_target", redirect_pc, 32'h200);
        run_br(3'd5, 32'h240, 16'h0004, 32'd3, 32'd0, 99, 0, 0);
        run_br(3'd7, 32'h260, 16'h0001, 32'd1, 32'd1, 3, 3, 0);
        run_br(3'd6, 32'h280, 16'h8000, 32'd0, 32'd0, 0, 0, 1);
        run_br(3'd6, 32'hFFFFFFF0, 16'h0010, 32'd0, 32'd0, 0, 0, 0);
        check("wrap_target", redirect_pc, 32'h00000034);
        run_br(3'd0, 32'h300, 16'h0001, 32'd9, 32'd9, 1, 4, 1);
        run_br(3'd4, 32'h320, 16'h0002, 32'd1, 32'd0, int'(MAXW), 0, 0);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            a  = ($urandom_range(0, 1) == 0) ? vals[$urandom_range(0, 7)] : $urandom;
            b  = ($urandom_range(0, 1) == 0) ? a : vals[$urandom_range(0, 7)];
            run_br(op, $urandom, 16'($urandom),
                   a, b,
                   ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 6),
                   ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 6),
                   $urandom_range(0, 3) == 0);
        end

        // Reset during the EVAL cycle of a taken beq
        br_valid = 1'b1; br_op = 3'd0; br_pc = 32'h400; br_off = 16'h0010;
        rs_val = 32'd9; rt_val = 32'd9; rs_rdy = 1'b1; rt_rdy = 1'b1;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        m_target = '0; m_taken = '0; m_stall = '0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_cmp_a", cmp_a, 32'd0);
        check("mid_rst_cmp_op", {29'd0, cmp_op}, 32'd0);
        check("mid_rst_redirect_pc", redirect_pc, 32'd0);
        check_stats();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        check("post_rst_redirect", {31'd0, redirect}, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_redirect2", {31'd0, redirect}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check_stats();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
